// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one iteration per cycle, busy/done handshake.
// Ports: clk, reset (async, active-low), start, funct3, a, b, kill ->
//        busy, done (1-cycle pulse), result (held until next done).
// Option: define MULDIV_EARLY_OUT_EN for early multiply exit.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int AW = 2*XLEN+1;
  localparam int PW = 2*XLEN;
  localparam int CW = $clog2(XLEN)+1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_FIX, S_DONE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_m;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_spec;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic            w_a_sgn, w_b_sgn;
  logic            w_a_neg, w_b_neg, w_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div0, w_ovf, w_spec;
  logic [XLEN-1:0] w_spec_val;

  assign w_a_sgn = funct3[2] ? ~funct3[0]
                 : (funct3[1:0] == 2'b01) | (funct3[1:0] == 2'b10);
  assign w_b_sgn = funct3[2] ? ~funct3[0]
                 : (funct3[1:0] == 2'b01);
  assign w_a_neg = w_a_sgn & a[XLEN-1];
  assign w_b_neg = w_b_sgn & b[XLEN-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;
  // remainder sign follows the dividend only
  assign w_neg = (funct3[2] & funct3[1]) ? w_a_neg
               : (w_a_neg ^ w_b_neg);
  assign w_div0 = funct3[2] & (b == '0);
  assign w_ovf  = funct3[2] & ~funct3[0]
                & (a == MIN) & (b == '1);

`ifdef MULDIV_EARLY_OUT_EN
  logic            w_mz;
  logic [XLEN-1:0] r_mplr;
  logic [XLEN-1:0] w_mplr_nx;
  assign w_mz = ~funct3[2] & ((a == '0) | (b == '0));
  assign w_mplr_nx = r_mplr >> 1;
  assign w_spec = w_div0 | w_ovf | w_mz;
`else
  assign w_spec = w_div0 | w_ovf;
`endif

  always_comb begin
    w_spec_val = '0;
    if (w_div0)
      w_spec_val = funct3[1] ? a : '1;
    else if (w_ovf)
      w_spec_val = funct3[1] ? '0 : a;
  end

  // multiply step: {upper(XLEN+1), mplr(XLEN)}
  logic [XLEN:0]   w_upper;
  logic [AW-1:0]   w_mul_nx;
  assign w_upper  = r_acc[AW-1:XLEN]
                  + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_nx = {1'b0, w_upper, r_acc[XLEN-1:1]};

  // divide step: {rem(XLEN+1), quot(XLEN)}, shifted left
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic            w_ge;
  logic [AW-1:0]   w_div_nx;
  assign w_rem_sh = r_acc[AW-2:XLEN-1];
  assign w_ge     = w_rem_sh >= {1'b0, r_m};
  assign w_diff   = w_rem_sh - {1'b0, r_m};
  assign w_div_nx = {w_ge ? w_diff : w_rem_sh,
                     r_acc[XLEN-2:0], w_ge};

  logic [AW-1:0]   w_step;
  logic            w_last;
  assign w_step = r_op[2] ? w_div_nx : w_mul_nx;
`ifdef MULDIV_EARLY_OUT_EN
  assign w_last = (r_cnt == CW'(XLEN-1))
                | (~r_op[2] & (w_mplr_nx == '0));
`else
  assign w_last = (r_cnt == CW'(XLEN-1));
`endif

  // result formation
  logic [PW-1:0]   w_prod, w_prod_s;
  logic [XLEN-1:0] w_q, w_r, w_q_s, w_r_s;
  logic [XLEN-1:0] w_res;
`ifdef MULDIV_EARLY_OUT_EN
  // skipped iterations would only have shifted right
  assign w_prod = PW'(r_acc >> (CW'(XLEN) - r_cnt));
`else
  assign w_prod = r_acc[PW-1:0];
`endif
  assign w_prod_s = r_neg ? -w_prod : w_prod;
  assign w_q   = r_acc[XLEN-1:0];
  assign w_r   = r_acc[PW-1:XLEN];
  assign w_q_s = r_neg ? -w_q : w_q;
  assign w_r_s = r_neg ? -w_r : w_r;

  always_comb begin
    w_res = '0;
    if (r_spec) begin
      w_res = r_acc[XLEN-1:0];
    end else begin
      unique case (r_op)
        3'b000:  w_res = w_prod_s[XLEN-1:0];
        3'b001,
        3'b010,
        3'b011:  w_res = w_prod_s[PW-1:XLEN];
        3'b100,
        3'b101:  w_res = w_q_s;
        default: w_res = w_r_s;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_spec   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      r_mplr   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && !kill) begin
            r_op   <= funct3;
            r_neg  <= w_neg;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_spec <= w_spec;
            r_m    <= funct3[2] ? w_b_mag : w_a_mag;
`ifdef MULDIV_EARLY_OUT_EN
            r_mplr <= w_b_mag;
`endif
            if (w_spec) begin
              r_acc   <= {{(XLEN+1){1'b0}}, w_spec_val};
              r_state <= S_FIX;
            end else begin
              r_acc   <= {{(XLEN+1){1'b0}},
                          funct3[2] ? w_a_mag : w_b_mag};
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CW'(1);
`ifdef MULDIV_EARLY_OUT_EN
            r_mplr <= w_mplr_nx;
`endif
            if (w_last)
              r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (kill) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_result <= w_res;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_spec  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, handshake
// and reset/kill sequences, random ops against an arithmetic model.
module tb_muldiv_sequencer;

  localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start),
    .funct3(funct3), .a(a), .b(b), .kill(kill),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat_d;
    int          lat_e;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(
    input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, uy;
    logic [63:0] p;
    int ix, iy;
    sx = $signed(x);
    sy = $signed(y);
    uy = {32'b0, y};
    ix = x;
    iy = y;
    p = '0;
    case (f)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return '1;
        if (x == MIN && y == '1) return x;
        return ix / iy;
      end
      3'd5: return (y == 0) ? '1 : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN && y == '1) return '0;
        return ix % iy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mag;
    int n;
    if (f[2]) begin
      if (y == 0) return 2;
      if (!f[0] && x == MIN && y == '1) return 2;
      return 34;
    end
    if (!EARLY) return 34;
    if (x == 0 || y == 0) return 2;
    mag = (f == 3'd1 && y[31]) ? -y : y;
    n = 0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) n = i + 1;
    return n + 2;
  endfunction

  task automatic do_op(input logic [2:0] f,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       output logic [31:0] res,
                       output int lat);
    lat = -1;
    res = '0;
    @(negedge clk);
    funct3 = f; a = x; b = y; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) check("busy_cycle1", 32'(busy), 32'd1);
      if (done) begin
        lat = c;
        res = result;
        check("busy_at_done", 32'(busy), 32'd1);
        break;
      end
    end
    if (lat < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL op_timeout: got no done, required done within 60");
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[16];

  initial begin
    logic [31:0] r;
    int lat, ndone;
    logic [2:0] rf;
    logic [31:0] ra, rb;

    vt[0]  = '{3'd0, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFD, 34, 4};
    vt[1]  = '{3'd1, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFF, 34, 4};
    vt[2]  = '{3'd3, 32'hFFFFFFFF, 32'h3, 32'h00000002, 34, 4};
    vt[3]  = '{3'd2, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 34, 4};
    vt[4]  = '{3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 34, 34};
    vt[5]  = '{3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 34, 34};
    vt[6]  = '{3'd5, 32'h1234, 32'h0, 32'hFFFFFFFF, 2, 2};
    vt[7]  = '{3'd7, 32'h1234, 32'h0, 32'h00001234, 2, 2};
    vt[8]  = '{3'd4, MIN, 32'hFFFFFFFF, MIN, 2, 2};
    vt[9]  = '{3'd6, MIN, 32'hFFFFFFFF, 32'h0, 2, 2};
    vt[10] = '{3'd5, 32'hFFFFFFFF, 32'd10, 32'h19999999, 34, 34};
    vt[11] = '{3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 34, 34};
    vt[12] = '{3'd3, 32'h10, 32'h3, 32'h0, 34, 4};
    vt[13] = '{3'd0, 32'h0, 32'h5, 32'h0, 34, 2};
    vt[14] = '{3'd0, 32'h5, 32'h0, 32'h0, 34, 2};
    vt[15] = '{3'd1, MIN, MIN, 32'h40000000, 34, 34};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b1;

    foreach (vt[i]) begin
      do_op(vt[i].f, vt[i].a, vt[i].b, r, lat);
      check($sformatf("vec%0d_res", i), r, vt[i].res);
      check($sformatf("vec%0d_lat", i), 32'(lat),
            32'(EARLY ? vt[i].lat_e : vt[i].lat_d));
    end

    // reset asserted mid-CALC discards the op
    @(negedge clk);
    funct3 = 3'd0; a = 32'd7; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    check("midrst_result", result, 32'd0);

    // extra starts in CALC and DONE are ignored
    @(negedge clk);
    funct3 = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
    ndone = 0;
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      start = (c == 5 || c == 34);
      if (c == 5) begin a = 32'd9; b = 32'd3; end
    end
    check("hs_done_count", 32'(ndone), 32'd1);
    check("hs_lat", 32'(lat), 32'd34);
    check("hs_result", result, 32'd14);
    check("hs_idle_busy", 32'(busy), 32'd0);

    // kill in cycle 10
    @(negedge clk);
    funct3 = 3'd0; a = 32'd123; b = 32'd456; start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) ndone++;
      if (c == 11) check("kill_busy", 32'(busy), 32'd0);
      kill = (c == 10);
    end
    check("kill_no_done", 32'(ndone), 32'd0);
    check("kill_result", result, 32'd14);

    // kill and start together in IDLE
    @(negedge clk);
    funct3 = 3'd5; a = 32'd50; b = 32'd5;
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("killstart_busy", 32'(busy), 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("killstart_no_done", 32'(ndone), 32'd0);

    // random ops against the model
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      do_op(rf, ra, rb, r, lat);
      check($sformatf("rnd%0d_f%0d_%h_%h_res", i, rf, ra, rb),
            r, ref_res(rf, ra, rb));
      check($sformatf("rnd%0d_lat", i), 32'(lat),
            32'(ref_lat(rf, ra, rb)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
